// File: rtl/cpu_pkg.sv
// Shared CPU back-end types: tag and data widths, reservation-station entry layout.
package cpu_pkg;

   localparam int unsigned TAG_W  = 6;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned FUNC_W = 4;

   localparam logic [TAG_W-1:0] NO_TAG = '0;

   typedef struct packed {
      logic              busy;
      logic [FUNC_W-1:0] func;
      logic [TAG_W-1:0]  rd_tag;
      logic [TAG_W-1:0]  src1_tag;
      logic [DATA_W-1:0] src1_data;
      logic [TAG_W-1:0]  src2_tag;
      logic [DATA_W-1:0] src2_data;
   } iq_entry_t;

endpackage

// File: rtl/cdb_if.sv
// Common data bus: one result broadcast per cycle; tag 0 carries no result.
interface cdb_if;
   import cpu_pkg::*;

   logic              valid;
   logic [TAG_W-1:0]  tag;
   logic [DATA_W-1:0] data;

   modport source (output valid, tag, data);
   modport snoop  (input  valid, tag, data);
endinterface

// File: rtl/iq_src_snoop.sv
// One source operand's CDB compare: on a tag hit, take the broadcast data and mark it valid.
module iq_src_snoop
   import cpu_pkg::*;
(
   input  logic              cdb_valid_i,
   input  logic [TAG_W-1:0]  cdb_tag_i,
   input  logic [DATA_W-1:0] cdb_data_i,
   input  logic [TAG_W-1:0]  tag_i,
   input  logic [DATA_W-1:0] data_i,
   output logic [TAG_W-1:0]  tag_o,
   output logic [DATA_W-1:0] data_o
);

   logic hit;

   // Tag 0 never matches, so idle broadcasts and already-valid operands are left alone.
   assign hit    = cdb_valid_i && (cdb_tag_i != NO_TAG) && (tag_i == cdb_tag_i);
   assign tag_o  = hit ? NO_TAG : tag_i;
   assign data_o = hit ? cdb_data_i : data_i;

endmodule

// File: rtl/int_issue_queue.sv
// Integer reservation-station queue: collapsing, oldest-ready-first select, CDB wakeup
// with same-cycle dispatch bypass.
module int_issue_queue #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             disp_valid,
   input  logic [3:0]       disp_func,
   input  logic [31:0]      disp_rs1_data,
   input  logic [31:0]      disp_rs2_data,
   input  logic [TAG_W-1:0] disp_rs1_tag,
   input  logic [TAG_W-1:0] disp_rs2_tag,
   input  logic [TAG_W-1:0] disp_rd_tag,
   output logic             queue_full,
   cdb_if.snoop             cdb,
   output logic             int_ready,
   output logic [3:0]       int_func,
   output logic [31:0]      int_rs1,
   output logic [31:0]      int_rs2,
   output logic [TAG_W-1:0] int_tag,
   input  logic             int_done
);

   import cpu_pkg::*;

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   iq_entry_t         ent_q [DEPTH];
   iq_entry_t         ent_d [DEPTH];
   iq_entry_t         woke  [DEPTH];
   iq_entry_t         disp_ent;
   iq_entry_t         sel_ent;

   logic [TAG_W-1:0]  w1_tag  [DEPTH];
   logic [DATA_W-1:0] w1_data [DEPTH];
   logic [TAG_W-1:0]  w2_tag  [DEPTH];
   logic [DATA_W-1:0] w2_data [DEPTH];
   logic [TAG_W-1:0]  d1_tag;
   logic [DATA_W-1:0] d1_data;
   logic [TAG_W-1:0]  d2_tag;
   logic [DATA_W-1:0] d2_data;

   logic [DEPTH-1:0]  busy_vec;
   logic [DEPTH-1:0]  rdy_vec;
   logic              sel_vld;
   logic [IDX_W-1:0]  sel_idx;
   logic              issue;
   logic              disp_fire;
   logic              disp_placed;

   // Per-entry wakeup of both sources from the live CDB broadcast.
   for (genvar g = 0; g < DEPTH; g++) begin : g_snoop
      iq_src_snoop u_src1 (
         .cdb_valid_i (cdb.valid),
         .cdb_tag_i   (cdb.tag),
         .cdb_data_i  (cdb.data),
         .tag_i       (ent_q[g].src1_tag),
         .data_i      (ent_q[g].src1_data),
         .tag_o       (w1_tag[g]),
         .data_o      (w1_data[g])
      );
      iq_src_snoop u_src2 (
         .cdb_valid_i (cdb.valid),
         .cdb_tag_i   (cdb.tag),
         .cdb_data_i  (cdb.data),
         .tag_i       (ent_q[g].src2_tag),
         .data_i      (ent_q[g].src2_data),
         .tag_o       (w2_tag[g]),
         .data_o      (w2_data[g])
      );
   end

   iq_src_snoop u_disp_src1 (
      .cdb_valid_i (cdb.valid),
      .cdb_tag_i   (cdb.tag),
      .cdb_data_i  (cdb.data),
      .tag_i       (disp_rs1_tag),
      .data_i      (disp_rs1_data),
      .tag_o       (d1_tag),
      .data_o      (d1_data)
   );

   iq_src_snoop u_disp_src2 (
      .cdb_valid_i (cdb.valid),
      .cdb_tag_i   (cdb.tag),
      .cdb_data_i  (cdb.data),
      .tag_i       (disp_rs2_tag),
      .data_i      (disp_rs2_data),
      .tag_o       (d2_tag),
      .data_o      (d2_data)
   );

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         woke[i]           = ent_q[i];
         woke[i].src1_tag  = w1_tag[i];
         woke[i].src1_data = w1_data[i];
         woke[i].src2_tag  = w2_tag[i];
         woke[i].src2_data = w2_data[i];
         busy_vec[i]       = ent_q[i].busy;
         rdy_vec[i]        = ent_q[i].busy && (ent_q[i].src1_tag == NO_TAG)
                                           && (ent_q[i].src2_tag == NO_TAG);
      end
   end

   always_comb begin
      disp_ent           = '0;
      disp_ent.busy      = 1'b1;
      disp_ent.func      = disp_func;
      disp_ent.rd_tag    = disp_rd_tag;
      disp_ent.src1_tag  = d1_tag;
      disp_ent.src1_data = d1_data;
      disp_ent.src2_tag  = d2_tag;
      disp_ent.src2_data = d2_data;
   end

   // Oldest-ready select: scanning from the top leaves the lowest ready index.
   always_comb begin
      sel_vld = 1'b0;
      sel_idx = '0;
      sel_ent = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (rdy_vec[i]) begin
            sel_vld = 1'b1;
            sel_idx = IDX_W'(i);
            sel_ent = ent_q[i];
         end
      end
   end

   assign int_ready  = sel_vld;
   assign int_func   = sel_ent.func;
   assign int_rs1    = sel_ent.src1_data;
   assign int_rs2    = sel_ent.src2_data;
   assign int_tag    = sel_ent.rd_tag;
   assign queue_full = &busy_vec;

   assign issue     = sel_vld && int_done;
   assign disp_fire = disp_valid && !queue_full;

   // Next state: wakeup, then collapse over the issued slot, then append dispatch; flush overrides.
   always_comb begin
      disp_placed = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = woke[i];
      end

      if (issue) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            if (IDX_W'(i) >= sel_idx) begin
               ent_d[i] = woke[i+1];
            end
         end
         ent_d[DEPTH-1] = '0;
      end

      if (disp_fire) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (!disp_placed && !ent_d[i].busy) begin
               ent_d[i]    = disp_ent;
               disp_placed = 1'b1;
            end
         end
      end

      if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
         end
      end
   end

endmodule

// File: tb/tb_int_issue_queue.sv
// Directed self-checking bench for int_issue_queue with hand-computed expectations.
module tb_int_issue_queue;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        disp_valid;
   logic [3:0]  disp_func;
   logic [31:0] disp_rs1_data;
   logic [31:0] disp_rs2_data;
   logic [5:0]  disp_rs1_tag;
   logic [5:0]  disp_rs2_tag;
   logic [5:0]  disp_rd_tag;
   logic        queue_full;
   logic        int_ready;
   logic [3:0]  int_func;
   logic [31:0] int_rs1;
   logic [31:0] int_rs2;
   logic [5:0]  int_tag;
   logic        int_done;

   int n_checks;
   int n_fail;

   cdb_if cdb_bus ();

   int_issue_queue #(.DEPTH(4), .TAG_W(6)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .disp_valid    (disp_valid),
      .disp_func     (disp_func),
      .disp_rs1_data (disp_rs1_data),
      .disp_rs2_data (disp_rs2_data),
      .disp_rs1_tag  (disp_rs1_tag),
      .disp_rs2_tag  (disp_rs2_tag),
      .disp_rd_tag   (disp_rd_tag),
      .queue_full    (queue_full),
      .cdb           (cdb_bus),
      .int_ready     (int_ready),
      .int_func      (int_func),
      .int_rs1       (int_rs1),
      .int_rs2       (int_rs2),
      .int_tag       (int_tag),
      .int_done      (int_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs and samples then sit 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic disp(input logic [3:0] f, input logic [5:0] t1, input logic [31:0] d1,
                       input logic [5:0] t2, input logic [31:0] d2, input logic [5:0] rd);
      disp_valid    = 1'b1;
      disp_func     = f;
      disp_rs1_tag  = t1;
      disp_rs1_data = d1;
      disp_rs2_tag  = t2;
      disp_rs2_data = d2;
      disp_rd_tag   = rd;
   endtask

   task automatic cdb_drive(input logic v, input logic [5:0] t, input logic [31:0] d);
      cdb_bus.valid = v;
      cdb_bus.tag   = t;
      cdb_bus.data  = d;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b0;
      flush = 1'b0;
      disp_valid = 1'b0;
      disp_func = '0;
      disp_rs1_data = '0;
      disp_rs2_data = '0;
      disp_rs1_tag = '0;
      disp_rs2_tag = '0;
      disp_rd_tag = '0;
      int_done = 1'b0;
      cdb_drive(1'b0, 6'd0, 32'd0);
      repeat (3) tick();

      check("rst_ready", 64'(int_ready), 64'd0);
      check("rst_full", 64'(queue_full), 64'd0);
      check("rst_tag", 64'(int_tag), 64'd0);
      check("rst_rs1", 64'(int_rs1), 64'd0);
      rst = 1'b1;
      tick();

      // Ready-at-dispatch entry issues the next cycle.
      int_done = 1'b1;
      disp(4'h0, 6'd0, 32'd5, 6'd0, 32'd7, 6'd3);
      tick();
      disp_valid = 1'b0;
      check("t1_ready", 64'(int_ready), 64'd1);
      check("t1_tag", 64'(int_tag), 64'd3);
      check("t1_rs1", 64'(int_rs1), 64'd5);
      check("t1_rs2", 64'(int_rs2), 64'd7);
      check("t1_func", 64'(int_func), 64'd0);
      tick();
      check("t1_empty", 64'(int_ready), 64'd0);
      check("t1_full", 64'(queue_full), 64'd0);
      int_done = 1'b0;

      // CDB wakeup of a pending source.
      disp(4'h1, 6'd9, 32'd0, 6'd0, 32'd2, 6'd4);
      tick();
      disp_valid = 1'b0;
      check("t2_pending", 64'(int_ready), 64'd0);
      cdb_drive(1'b1, 6'd9, 32'hDEAD);
      check("t2_same_cyc", 64'(int_ready), 64'd0);
      tick();
      cdb_drive(1'b0, 6'd0, 32'd0);
      check("t2_ready", 64'(int_ready), 64'd1);
      check("t2_rs1", 64'(int_rs1), 64'hDEAD);
      check("t2_rs2", 64'(int_rs2), 64'd2);
      check("t2_func", 64'(int_func), 64'd1);
      int_done = 1'b1;
      tick();
      int_done = 1'b0;
      check("t2_empty", 64'(int_ready), 64'd0);

      // Fill with pending entries, dispatch held while full.
      for (int i = 0; i < 4; i++) begin
         disp(4'h2, 6'(10 + i), 32'd0, 6'd0, 32'(100 + i), 6'(20 + i));
         tick();
      end
      disp_valid = 1'b0;
      check("t3_full", 64'(queue_full), 64'd1);
      check("t3_notrdy", 64'(int_ready), 64'd0);
      disp(4'h3, 6'd0, 32'd1, 6'd0, 32'd1, 6'd30);
      tick();
      disp_valid = 1'b0;
      check("t3_held_full", 64'(queue_full), 64'd1);
      check("t3_held_rdy", 64'(int_ready), 64'd0);
      cdb_drive(1'b1, 6'd12, 32'h1212);
      tick();
      cdb_drive(1'b0, 6'd0, 32'd0);
      check("t3_e2_ready", 64'(int_ready), 64'd1);
      check("t3_e2_tag", 64'(int_tag), 64'd22);
      check("t3_e2_rs1", 64'(int_rs1), 64'h1212);
      check("t3_e2_rs2", 64'(int_rs2), 64'd102);
      int_done = 1'b1;
      tick();
      int_done = 1'b0;
      check("t3_not_full", 64'(queue_full), 64'd0);
      check("t3_after", 64'(int_ready), 64'd0);

      // Wake entries 1 and 3; hold entry 1, then drain both in order.
      cdb_drive(1'b1, 6'd11, 32'h1111);
      tick();
      cdb_drive(1'b1, 6'd13, 32'h1313);
      check("t4_e1_tag", 64'(int_tag), 64'd21);
      tick();
      cdb_drive(1'b0, 6'd0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         check("t4_hold_tag", 64'(int_tag), 64'd21);
         check("t4_hold_rs1", 64'(int_rs1), 64'h1111);
         check("t4_hold_rs2", 64'(int_rs2), 64'd101);
         tick();
      end
      int_done = 1'b1;
      tick();
      check("t4_e3_ready", 64'(int_ready), 64'd1);
      check("t4_e3_tag", 64'(int_tag), 64'd23);
      check("t4_e3_rs1", 64'(int_rs1), 64'h1313);
      check("t4_e3_rs2", 64'(int_rs2), 64'd103);
      tick();
      int_done = 1'b0;
      check("t4_drained", 64'(int_ready), 64'd0);

      // Tag-0 broadcast is ignored; dispatch bypass takes live CDB data.
      disp(4'h4, 6'd5, 32'd0, 6'd0, 32'd9, 6'd40);
      tick();
      disp_valid = 1'b0;
      cdb_drive(1'b1, 6'd0, 32'h5555);
      tick();
      cdb_drive(1'b0, 6'd0, 32'd0);
      check("t5_tag0_ign", 64'(int_ready), 64'd0);
      disp(4'h5, 6'd0, 32'h77, 6'd5, 32'd0, 6'd41);
      cdb_drive(1'b1, 6'd5, 32'hBEEF);
      tick();
      disp_valid = 1'b0;
      cdb_drive(1'b0, 6'd0, 32'd0);
      check("t5_a_tag", 64'(int_tag), 64'd40);
      check("t5_a_rs1", 64'(int_rs1), 64'hBEEF);
      check("t5_a_rs2", 64'(int_rs2), 64'd9);
      int_done = 1'b1;
      tick();
      check("t5_b_ready", 64'(int_ready), 64'd1);
      check("t5_b_tag", 64'(int_tag), 64'd41);
      check("t5_b_rs1", 64'(int_rs1), 64'h77);
      check("t5_b_rs2", 64'(int_rs2), 64'hBEEF);
      check("t5_b_func", 64'(int_func), 64'd5);
      tick();
      int_done = 1'b0;
      check("t5_drained", 64'(int_ready), 64'd0);

      // Three busy entries, then flush beats a same-cycle dispatch.
      disp(4'h6, 6'd50, 32'd0, 6'd0, 32'd0, 6'd50);
      tick();
      disp(4'h6, 6'd51, 32'd0, 6'd0, 32'd0, 6'd51);
      tick();
      disp_valid = 1'b0;
      check("t6_not_full", 64'(queue_full), 64'd0);
      flush = 1'b1;
      int_done = 1'b1;
      disp(4'h7, 6'd0, 32'd1, 6'd0, 32'd1, 6'd60);
      tick();
      flush = 1'b0;
      int_done = 1'b0;
      disp_valid = 1'b0;
      check("t6_flush_rdy", 64'(int_ready), 64'd0);
      check("t6_flush_full", 64'(queue_full), 64'd0);
      // Remaining pending entries must be gone: waking their tags produces nothing.
      cdb_drive(1'b1, 6'd10, 32'hAAAA);
      tick();
      cdb_drive(1'b0, 6'd0, 32'd0);
      check("t6_no_ghost", 64'(int_ready), 64'd0);

      // Asynchronous reset mid-operation.
      disp(4'h8, 6'd0, 32'd1, 6'd0, 32'd2, 6'd61);
      tick();
      disp_valid = 1'b0;
      check("t7_ready", 64'(int_ready), 64'd1);
      check("t7_tag", 64'(int_tag), 64'd61);
      #2;
      rst = 1'b0;
      #1;
      check("t7_rst_ready", 64'(int_ready), 64'd0);
      check("t7_rst_tag", 64'(int_tag), 64'd0);
      check("t7_rst_rs1", 64'(int_rs1), 64'd0);
      check("t7_rst_full", 64'(queue_full), 64'd0);
      tick();
      rst = 1'b1;
      repeat (2) tick();
      check("t7_post_rst", 64'(int_ready), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
